// File: rtl/m_dm_ctrl.sv
// M-stage data-memory controller: sequences pipeline loads/stores and word-only
// debug accesses onto one variable-latency memory port.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | arbitrate between the pipeline op and a debug request
// CPU_WAIT | CPU access presented on the memory port, waiting for mem_ack
// CPU_DONE | cpu_done pulse, pipeline released for this cycle
// CPU_ERR  | cpu_exc pulse for a misaligned access, no memory cycle made
// DBG_WAIT | debug access presented on the memory port, waiting for mem_ack
// DBG_DONE | dbg_ack pulse, dbg_rdata valid
module m_dm_ctrl #(
   parameter int unsigned MAX_WAIT = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  cpu_op,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        m_stall,
   output logic        cpu_done,
   output logic        cpu_exc,
   output logic [31:0] ld_data,
   output logic [1:0]  ld_a,
   output logic [3:0]  ld_op,
   input  logic        dbg_req,
   input  logic        dbg_we,
   input  logic [31:0] dbg_addr,
   input  logic [31:0] dbg_wdata,
   output logic        dbg_ack,
   output logic [31:0] dbg_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [2:0] {
      IDLE, CPU_WAIT, CPU_DONE, CPU_ERR, DBG_WAIT, DBG_DONE
   } state_t;

   localparam logic [3:0] OP_LW  = 4'd1;
   localparam logic [3:0] OP_LH  = 4'd2;
   localparam logic [3:0] OP_LHU = 4'd3;
   localparam logic [3:0] OP_LBU = 4'd5;
   localparam logic [3:0] OP_SW  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SB  = 4'd8;
   localparam logic [3:0] STARVE_INIT = 4'(MAX_WAIT);
   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

   state_t      state;
   logic [3:0]  starve_cnt;
   logic        cpu_valid;
   logic        cpu_load;
   logic        cpu_misal;
   logic        starved;
   logic        dbg_win;
   logic [3:0]  be_nxt;
   logic [31:0] wdata_nxt;

   always_comb begin
      cpu_valid = (cpu_op >= OP_LW) && (cpu_op <= OP_SB);
      cpu_load  = (cpu_op >= OP_LW) && (cpu_op <= OP_LBU);
      starved   = (starve_cnt == 4'd0);
      dbg_win   = dbg_req && (!cpu_valid || starved);
      m_stall   = cpu_valid && (state != CPU_DONE) && (state != CPU_ERR);
   end

   always_comb begin
      be_nxt    = 4'b1111;
      wdata_nxt = cpu_wdata;
      cpu_misal = 1'b0;
      case (cpu_op)
         OP_LW, OP_SW:  cpu_misal = (cpu_addr[1:0] != 2'b00);
         OP_LH, OP_LHU: cpu_misal = cpu_addr[0];
         OP_SH: begin
            cpu_misal = cpu_addr[0];
            be_nxt    = cpu_addr[1] ? 4'b1100 : 4'b0011;
            wdata_nxt = {2{cpu_wdata[15:0]}};
         end
         OP_SB: begin
            be_nxt    = 4'b0001 << cpu_addr[1:0];
            wdata_nxt = {4{cpu_wdata[7:0]}};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         starve_cnt <= STARVE_INIT;
         cpu_done   <= 1'b0;
         cpu_exc    <= 1'b0;
         dbg_ack    <= 1'b0;
         ld_data    <= 32'd0;
         ld_a       <= 2'd0;
         ld_op      <= 4'd0;
         dbg_rdata  <= 32'd0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_be     <= 4'd0;
         mem_addr   <= 32'd0;
         mem_wdata  <= 32'd0;
      end else begin
         cpu_done <= 1'b0;
         cpu_exc  <= 1'b0;
         dbg_ack  <= 1'b0;

         // starvation timer only runs while debug is refused
         if (!dbg_req) begin
            starve_cnt <= STARVE_INIT;
         end else if ((state != DBG_WAIT) && (state != DBG_DONE) && !starved) begin
            starve_cnt <= starve_cnt - 4'd1;
         end

         case (state)
            IDLE: begin
               if (dbg_win) begin
                  starve_cnt <= STARVE_INIT;
                  state      <= DBG_WAIT;
                  mem_req    <= 1'b1;
                  mem_we     <= dbg_we;
                  mem_be     <= 4'b1111;
                  mem_addr   <= dbg_addr & WORD_MASK;
                  mem_wdata  <= dbg_wdata;
               end else if (cpu_valid) begin
                  if (cpu_misal) begin
                     state   <= CPU_ERR;
                     cpu_exc <= 1'b1;
                  end else begin
                     state     <= CPU_WAIT;
                     mem_req   <= 1'b1;
                     mem_we    <= !cpu_load;
                     mem_be    <= be_nxt;
                     mem_addr  <= cpu_addr & WORD_MASK;
                     mem_wdata <= wdata_nxt;
                     if (cpu_load) begin
                        ld_a  <= cpu_addr[1:0];
                        ld_op <= cpu_op;
                     end
                  end
               end
            end
            CPU_WAIT: begin
               if (mem_ack) begin
                  mem_req  <= 1'b0;
                  cpu_done <= 1'b1;
                  state    <= CPU_DONE;
                  if (!mem_we) ld_data <= mem_rdata;
               end
            end
            DBG_WAIT: begin
               if (mem_ack) begin
                  mem_req   <= 1'b0;
                  dbg_rdata <= mem_rdata;
                  dbg_ack   <= 1'b1;
                  state     <= DBG_DONE;
               end
            end
            CPU_DONE, CPU_ERR, DBG_DONE: state <= IDLE;
            default:                     state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_m_dm_ctrl.sv
// Scoreboard bench for m_dm_ctrl: a word-array memory device answers the port,
// a reference model predicts every CPU/debug response and memory transaction.
module tb_m_dm_ctrl;
   localparam int MAX_WAIT = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  cpu_op;
   logic [31:0] cpu_addr, cpu_wdata;
   logic        m_stall, cpu_done, cpu_exc;
   logic [31:0] ld_data;
   logic [1:0]  ld_a;
   logic [3:0]  ld_op;
   logic        dbg_req, dbg_we;
   logic [31:0] dbg_addr, dbg_wdata;
   logic        dbg_ack;
   logic [31:0] dbg_rdata;
   logic        mem_req, mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   m_dm_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset),
      .cpu_op(cpu_op), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .m_stall(m_stall), .cpu_done(cpu_done), .cpu_exc(cpu_exc),
      .ld_data(ld_data), .ld_a(ld_a), .ld_op(ld_op),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          exc;
      bit          is_load;
      logic [31:0] data;
      logic [1:0]  a;
      logic [3:0]  op;
   } cpu_exp_t;
   typedef struct {
      bit          we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_exp_t;
   typedef struct {
      bit          chk;
      logic [31:0] data;
   } dbg_exp_t;

   cpu_exp_t cpu_q[$];
   dbg_exp_t dbg_q[$];
   mem_exp_t cpu_mem_q[$];
   mem_exp_t dbg_mem_q[$];
   bit       src_log[$];

   // address bit 15 selects the debug region; both regions alias 64 words
   logic [31:0] cpu_dev[64], cpu_ref[64], dbg_dev[64], dbg_ref[64];

   int checks = 0;
   int errors = 0;
   int n_cpu_resp = 0;
   int ack_dly = 1;
   bit mem_auto = 1'b1;
   bit busy = 1'b0;
   bit stall_at_dbg_ack = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_cpu(input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] wd, output bit valid);
      int size, w, ofs;
      bit ld;
      cpu_exp_t e;
      mem_exp_t m;
      w = int'(addr[7:2]);
      ofs = int'(addr[1:0]);
      valid = 1'b1;
      size = 1;
      ld = 1'b0;
      case (op)
         4'd1:       begin size = 4; ld = 1'b1; end
         4'd2, 4'd3: begin size = 2; ld = 1'b1; end
         4'd4, 4'd5: begin size = 1; ld = 1'b1; end
         4'd6:       size = 4;
         4'd7:       size = 2;
         4'd8:       size = 1;
         default:    valid = 1'b0;
      endcase
      if (!valid) return;
      e.exc = (ofs % size) != 0;
      e.is_load = ld;
      e.data = cpu_ref[w];
      e.a = addr[1:0];
      e.op = op;
      cpu_q.push_back(e);
      if (e.exc) return;
      m.we = !ld;
      m.addr = addr & 32'hFFFF_FFFC;
      m.be = 4'd0;
      m.wdata = 32'd0;
      for (int k = 0; k < 4; k++) begin
         if (ld || (k >= ofs && k < ofs + size)) m.be[k] = 1'b1;
         m.wdata[8*k +: 8] = wd[8*(k % size) +: 8];
         if (!ld && k >= ofs && k < ofs + size) cpu_ref[w][8*k +: 8] = wd[8*(k % size) +: 8];
      end
      cpu_mem_q.push_back(m);
   endtask

   task automatic model_dbg(input bit we, input logic [31:0] addr, input logic [31:0] wd);
      int w;
      dbg_exp_t e;
      mem_exp_t m;
      w = int'(addr[7:2]);
      e.chk = !we;
      e.data = dbg_ref[w];
      dbg_q.push_back(e);
      m.we = we;
      m.be = 4'b1111;
      m.addr = addr & 32'hFFFF_FFFC;
      m.wdata = wd;
      dbg_mem_q.push_back(m);
      if (we) dbg_ref[w] = wd;
   endtask

   // Called at posedge+1; returns at posedge+1 after the op has been consumed.
   task automatic cpu_access(input logic [3:0] op, input logic [31:0] addr,
                             input logic [31:0] wd, output int n_stall);
      bit valid;
      model_cpu(op, addr, wd, valid);
      cpu_op = op;
      cpu_addr = addr;
      cpu_wdata = wd;
      n_stall = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!m_stall) break;
         n_stall++;
      end
      check("cpu_stall_bound", n_stall < 300, 1'b1);
      if (!valid) check("none_op_stall", n_stall, 0);
      @(posedge clk);
      #1;
      cpu_op = 4'd0;
      cpu_addr = $urandom;
      cpu_wdata = $urandom;
   endtask

   task automatic dbg_access(input bit we, input logic [31:0] addr,
                             input logic [31:0] wd, output int lat);
      model_dbg(we, addr, wd);
      dbg_req = 1'b1;
      dbg_we = we;
      dbg_addr = addr;
      dbg_wdata = wd;
      lat = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (dbg_ack) break;
         lat++;
      end
      check("dbg_ack_bound", lat < 500, 1'b1);
      @(posedge clk);
      #1;
      dbg_req = 1'b0;
      dbg_we = $urandom;
      dbg_addr = $urandom;
      dbg_wdata = $urandom;
   endtask

   // memory device: ack after ack_dly (or random 1..4) request cycles
   initial begin : mem_device
      int cnt, dly, idx;
      logic [68:0] snap;
      mem_exp_t m;
      mem_ack = 1'b0;
      mem_rdata = 32'd0;
      cnt = 0;
      dly = 1;
      forever begin
         @(negedge clk);
         if (mem_auto) begin
            mem_ack = 1'b0;
            if (mem_req) begin
               if (!busy) begin
                  busy = 1'b1;
                  cnt = 0;
                  snap = {mem_we, mem_be, mem_addr, mem_wdata};
                  dly = (ack_dly != 0) ? ack_dly : int'($urandom_range(1, 4));
                  src_log.push_back(mem_addr[15]);
                  if (mem_addr[15]) begin
                     check("dbg_mem_expected", dbg_mem_q.size() != 0, 1'b1);
                     if (dbg_mem_q.size() != 0) m = dbg_mem_q.pop_front();
                  end else begin
                     check("cpu_mem_expected", cpu_mem_q.size() != 0, 1'b1);
                     if (cpu_mem_q.size() != 0) m = cpu_mem_q.pop_front();
                  end
                  check("mem_addr", mem_addr, m.addr);
                  check("mem_be", mem_be, m.be);
                  check("mem_we", mem_we, m.we);
                  if (m.we) check("mem_wdata", mem_wdata, m.wdata);
               end else begin
                  check("mem_hold", {mem_we, mem_be, mem_addr, mem_wdata} == snap, 1'b1);
               end
               cnt++;
               if (cnt >= dly) begin
                  idx = int'(mem_addr[7:2]);
                  if (mem_addr[15]) begin
                     mem_rdata = dbg_dev[idx];
                     for (int k = 0; k < 4; k++)
                        if (mem_we && mem_be[k]) dbg_dev[idx][8*k +: 8] = mem_wdata[8*k +: 8];
                  end else begin
                     mem_rdata = cpu_dev[idx];
                     for (int k = 0; k < 4; k++)
                        if (mem_we && mem_be[k]) cpu_dev[idx][8*k +: 8] = mem_wdata[8*k +: 8];
                  end
                  mem_ack = 1'b1;
                  busy = 1'b0;
               end
            end
         end
      end
   end

   initial begin : monitor
      cpu_exp_t ce;
      dbg_exp_t de;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (cpu_done || cpu_exc) begin
               n_cpu_resp++;
               check("cpu_resp_expected", cpu_q.size() != 0, 1'b1);
               if (cpu_q.size() != 0) begin
                  ce = cpu_q.pop_front();
                  check("cpu_resp_kind", {cpu_exc, cpu_done}, ce.exc ? 2'b10 : 2'b01);
                  if (!ce.exc && ce.is_load) begin
                     check("ld_data", ld_data, ce.data);
                     check("ld_a", ld_a, ce.a);
                     check("ld_op", ld_op, ce.op);
                  end
               end
            end
            if (dbg_ack) begin
               stall_at_dbg_ack = m_stall;
               check("dbg_resp_expected", dbg_q.size() != 0, 1'b1);
               if (dbg_q.size() != 0) begin
                  de = dbg_q.pop_front();
                  if (de.chk) check("dbg_rdata", dbg_rdata, de.data);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int ns, lat, base, exp_k;
      logic [31:0] w0;
      for (int i = 0; i < 64; i++) begin
         w0 = $urandom;
         cpu_dev[i] = w0;
         cpu_ref[i] = w0;
         w0 = $urandom;
         dbg_dev[i] = w0;
         dbg_ref[i] = w0;
      end
      reset = 1'b1;
      cpu_op = 4'd0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 32'd0; dbg_wdata = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_we_be", {mem_we, mem_be}, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_ld", {ld_data, ld_a, ld_op}, 0);
      check("rst_dbg_rdata", dbg_rdata, 0);
      check("rst_pulses", {cpu_done, cpu_exc, dbg_ack, m_stall}, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // lw at 0x1004, immediate ack
      ack_dly = 1;
      cpu_access(4'd1, 32'h0000_1004, 32'h0, ns);
      check("lw_stall_cycles", ns, 2);
      check("lw_resp_seen", cpu_q.size(), 0);

      // sb at 0x2003 with a 4-cycle ack
      ack_dly = 4;
      cpu_access(4'd8, 32'h0000_2003, 32'h1234_56AB, ns);
      check("sb_stall_cycles", ns, 5);
      check("sb_resp_seen", cpu_q.size(), 0);
      ack_dly = 1;
      cpu_access(4'd1, 32'h0000_2000, 32'h0, ns);

      // misaligned accesses never reach memory
      src_log.delete();
      cpu_access(4'd7, 32'h0000_2001, 32'h5555_AAAA, ns);
      check("sh_misal_stall", ns, 1);
      cpu_access(4'd1, 32'h0000_2002, 32'h0, ns);
      check("lw_misal_stall", ns, 1);
      check("misal_no_mem", src_log.size(), 0);
      check("misal_resp_seen", cpu_q.size(), 0);

      // simultaneous lw and debug request with an idle starvation count
      src_log.delete();
      fork
         begin
            int ns1;
            cpu_access(4'd1, 32'h0000_1020, 32'h0, ns1);
         end
         begin
            int lat1;
            dbg_access(1'b0, 32'h0000_8024, 32'h0, lat1);
            check("simul_dbg_lat", lat1, 5);
         end
      join
      check("simul_order", {src_log.size() == 2, src_log[0], src_log[1]}, 3'b101);

      // starvation: back-to-back lw against a held debug request
      exp_k = (MAX_WAIT + 2) / 3;
      base = n_cpu_resp;
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               int ns2;
               cpu_access(4'd1, 32'h0000_1000 + 32'(4 * i), 32'h0, ns2);
            end
         end
         begin
            int lat2;
            dbg_access(1'b0, 32'h0000_8010, 32'h0, lat2);
            check("starve_dbg_lat", lat2, 3 * exp_k + 2);
            check("starve_cpu_before", n_cpu_resp - base, exp_k);
            check("starve_stall_in_dbg", stall_at_dbg_ack, 1'b1);
         end
      join

      // reset while CPU_WAIT, ack arriving afterwards
      mem_auto = 1'b0;
      busy = 1'b0;
      mem_ack = 1'b0;
      cpu_op = 4'd1;
      cpu_addr = 32'h0000_1008;
      @(posedge clk);
      #1;
      check("rst_mid_req_up", mem_req, 1'b1);
      reset = 1'b1;
      cpu_op = 4'd0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      mem_ack = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      check("rst_mid_req_drop", mem_req, 1'b0);
      check("rst_mid_no_done", cpu_done, 1'b0);
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      @(negedge clk);
      check("rst_late_ack_ignored", {mem_req, cpu_done, m_stall}, 3'b000);
      check("rst_ld_data", ld_data, 32'd0);
      @(posedge clk);
      #1;
      mem_auto = 1'b1;

      // randomized mix with concurrent debug traffic and random ack delays
      ack_dly = 0;
      fork
         begin
            for (int i = 0; i < 200; i++) begin
               logic [3:0] rop;
               logic [31:0] ra;
               int ns3;
               rop = 4'($urandom_range(0, 15));
               ra = 32'h0000_1000 | ($urandom & 32'h0000_00FF);
               if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
               cpu_access(rop, ra, $urandom, ns3);
            end
         end
         begin
            for (int j = 0; j < 30; j++) begin
               int gap, lat3;
               gap = int'($urandom_range(0, 6));
               if (gap > 0) begin
                  repeat (gap) @(posedge clk);
                  #1;
               end
               dbg_access(1'($urandom_range(0, 1)),
                          32'h0000_8000 | ($urandom & 32'h0000_00FF), $urandom, lat3);
            end
         end
      join

      repeat (10) @(posedge clk);
      check("cpu_q_drained", cpu_q.size(), 0);
      check("dbg_q_drained", dbg_q.size(), 0);
      check("cpu_mem_q_drained", cpu_mem_q.size(), 0);
      check("dbg_mem_q_drained", dbg_mem_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
